// File: rtl/vpu_alu_vec_iadd_if.sv
// Operand/result bus for vpu_alu_vec_iadd. Optional ovf_o exists only when
// VPU_IADD_OVF_FLAG_EN is defined.
interface vpu_alu_vec_iadd_if #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [LANES*ELEM_W-1:0]   op_0_i;
    logic [LANES*ELEM_W-1:0]   op_1_i;
    logic [LANES*ELEM_W-1:0]   op_2_i;
    logic                      op2_en_i;
    logic [1:0]                mode_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [LANES*ELEM_W-1:0]   result_o;
`ifdef VPU_IADD_OVF_FLAG_EN
    logic [LANES-1:0]          ovf_o;
`endif

    modport slave (
        input  in_valid_i, op_0_i, op_1_i, op_2_i, op2_en_i, mode_i, out_ready_i,
`ifdef VPU_IADD_OVF_FLAG_EN
        output ovf_o,
`endif
        output in_ready_o, out_valid_o, result_o
    );

    modport master (
        output in_valid_i, op_0_i, op_1_i, op_2_i, op2_en_i, mode_i, out_ready_i,
`ifdef VPU_IADD_OVF_FLAG_EN
        input  ovf_o,
`endif
        input  in_ready_o, out_valid_o, result_o
    );
endinterface

// File: rtl/vpu_alu_vec_iadd.sv
// Multi-lane pipelined integer adder (wrap / unsigned-sat / signed-sat per beat).
// Define VPU_IADD_OVF_FLAG_EN to add the per-lane overflow flag output ovf_o.
module vpu_alu_vec_iadd #(
    parameter int LANES       = 4,
    parameter int ELEM_W      = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vpu_alu_vec_iadd_if.slave    bus
);
    localparam int RW   = LANES * ELEM_W;
    localparam int XW   = ELEM_W + 2;
    localparam int LAST = PIPE_STAGES - 1;

    // Handshake: a beat transfers on a side when its valid and ready are both
    // high at the rising edge; a producer holds valid and data until it transfers.
    // The whole pipeline advances when the output slot is empty or being popped.

    function automatic logic [XW-1:0] lane_sum(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic [ELEM_W-1:0] c,
        input logic              en,
        input logic [1:0]        mode
    );
        logic          sx;
        logic [XW-1:0] ea;
        logic [XW-1:0] eb;
        logic [XW-1:0] ec;
        sx = (mode == 2'b10);
        ea = {{2{sx & a[ELEM_W-1]}}, a};
        eb = {{2{sx & b[ELEM_W-1]}}, b};
        ec = en ? {{2{sx & c[ELEM_W-1]}}, c} : '0;
        return ea + eb + ec;
    endfunction

    function automatic logic [ELEM_W-1:0] lane_sat(input logic [XW-1:0] s, input logic [1:0] mode);
        logic [ELEM_W-1:0] r;
        r = s[ELEM_W-1:0];
        case (mode)
            2'b01: if (|s[XW-1:ELEM_W]) r = '1;
            2'b10: begin
                // In range iff the top three bits of the signed sum agree.
                if (~s[XW-1] & (|s[XW-2:ELEM_W-1]))
                    r = {1'b0, {(ELEM_W-1){1'b1}}};
                else if (s[XW-1] & ~(&s[XW-2:ELEM_W-1]))
                    r = {1'b1, {(ELEM_W-1){1'b0}}};
            end
            default: r = s[ELEM_W-1:0];
        endcase
        return r;
    endfunction

`ifdef VPU_IADD_OVF_FLAG_EN
    function automatic logic lane_ovf(input logic [XW-1:0] s, input logic [1:0] mode);
        logic f;
        if (mode == 2'b10)
            f = (~s[XW-1] & (|s[XW-2:ELEM_W-1])) | (s[XW-1] & ~(&s[XW-2:ELEM_W-1]));
        else
            f = |s[XW-1:ELEM_W];
        return f;
    endfunction
`endif

    logic [XW-1:0]    sum_w [LANES];
    logic [RW-1:0]    res_d;
    logic             valid_d;
    logic             adv;
    logic             valid_q [PIPE_STAGES];
    logic [RW-1:0]    res_q   [PIPE_STAGES];
`ifdef VPU_IADD_OVF_FLAG_EN
    logic [LANES-1:0] ovf_d;
    logic [LANES-1:0] ovf_q   [PIPE_STAGES];
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign sum_w[k] = lane_sum(bus.op_0_i[k*ELEM_W +: ELEM_W],
                                   bus.op_1_i[k*ELEM_W +: ELEM_W],
                                   bus.op_2_i[k*ELEM_W +: ELEM_W],
                                   bus.op2_en_i, bus.mode_i);
    end

    always_comb begin
        res_d = '0;
`ifdef VPU_IADD_OVF_FLAG_EN
        ovf_d = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            res_d[k*ELEM_W +: ELEM_W] = lane_sat(sum_w[k], bus.mode_i);
`ifdef VPU_IADD_OVF_FLAG_EN
            ovf_d[k] = lane_ovf(sum_w[k], bus.mode_i);
`endif
        end
    end

    assign valid_d        = bus.in_valid_i;
    assign adv            = ~valid_q[LAST] | bus.out_ready_i;
    assign bus.in_ready_o = adv;

    // Stage 0 holds the computed beat; later stages are pure delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                valid_q[s] <= 1'b0;
                res_q[s]   <= '0;
`ifdef VPU_IADD_OVF_FLAG_EN
                ovf_q[s]   <= '0;
`endif
            end
        end else if (adv) begin
            valid_q[0] <= valid_d;
            res_q[0]   <= res_d;
`ifdef VPU_IADD_OVF_FLAG_EN
            ovf_q[0]   <= ovf_d;
`endif
            for (int s = 1; s < PIPE_STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                res_q[s]   <= res_q[s-1];
`ifdef VPU_IADD_OVF_FLAG_EN
                ovf_q[s]   <= ovf_q[s-1];
`endif
            end
        end
    end

    assign bus.out_valid_o = valid_q[LAST];
    assign bus.result_o    = res_q[LAST];
`ifdef VPU_IADD_OVF_FLAG_EN
    assign bus.ovf_o       = ovf_q[LAST];
`endif
endmodule

// File: tb/tb_vpu_alu_vec_iadd.sv
// Self-checking bench for vpu_alu_vec_iadd: directed vector table, backpressure
// and reset sequences, then randomized traffic against an integer reference model.
module tb_vpu_alu_vec_iadd;
    localparam int LANES  = 4;
    localparam int ELEM_W = 8;
    localparam int PIPE   = 2;
    localparam int RW     = LANES * ELEM_W;
    localparam int NV     = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vpu_alu_vec_iadd_if #(.LANES(LANES), .ELEM_W(ELEM_W)) ifc ();

    vpu_alu_vec_iadd #(.LANES(LANES), .ELEM_W(ELEM_W), .PIPE_STAGES(PIPE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [RW-1:0]    a;
        logic [RW-1:0]    b;
        logic [RW-1:0]    c;
        logic             en;
        logic [1:0]       mode;
        logic [RW-1:0]    res;
        logic [LANES-1:0] ovf;
    } vec_t;

    vec_t vecs [NV];
    logic [RW+LANES-1:0] exp_q [$];
    bit                  prev_stall = 1'b0;
    logic [RW-1:0]       prev_res;
    bit                  rand_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic per lane. Returns {ovf, result}.
    function automatic logic [RW+LANES-1:0] ref_beat(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                                     input logic [RW-1:0] c, input logic en,
                                                     input logic [1:0] mode);
        logic [RW-1:0]    r;
        logic [LANES-1:0] o;
        int va, vb, vc, s, lo, hi, full, half;
        full = 1 << ELEM_W;
        half = 1 << (ELEM_W - 1);
        r = '0;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            va = int'(a[k*ELEM_W +: ELEM_W]);
            vb = int'(b[k*ELEM_W +: ELEM_W]);
            vc = en ? int'(c[k*ELEM_W +: ELEM_W]) : 0;
            if (mode == 2'b10) begin
                if (va >= half) va -= full;
                if (vb >= half) vb -= full;
                if (vc >= half) vc -= full;
                lo = -half;
                hi = half - 1;
            end else begin
                lo = 0;
                hi = full - 1;
            end
            s = va + vb + vc;
            o[k] = (s < lo) || (s > hi);
            if (mode == 2'b01 || mode == 2'b10) begin
                if (s > hi) s = hi;
                if (s < lo) s = lo;
            end else begin
                s = s % full;
            end
            r[k*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
        end
        return {o, r};
    endfunction

    task automatic send(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] c,
                        input logic en, input logic [1:0] mode);
        bit ok;
        ok = 1'b0;
        ifc.op_0_i     = a;
        ifc.op_1_i     = b;
        ifc.op_2_i     = c;
        ifc.op2_en_i   = en;
        ifc.mode_i     = mode;
        ifc.in_valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ifc.in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(ref_beat(a, b, c, en, mode));
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready_o stayed 0 for 200 cycles");
        end
        ifc.in_valid_i = 1'b0;
    endtask

    // Scoreboard: every popped beat must match the oldest expectation; a
    // stalled output must hold its value.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(ifc.out_valid_o), 64'd1);
                chk("hold_result", 64'(ifc.result_o), 64'(prev_res));
            end
            if (ifc.out_valid_o && ifc.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(ifc.result_o), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    logic [RW+LANES-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_result", 64'(ifc.result_o), 64'(e[RW-1:0]));
`ifdef VPU_IADD_OVF_FLAG_EN
                    chk("sb_ovf", 64'(ifc.ovf_o), 64'(e[RW +: LANES]));
`endif
                end
            end
            prev_stall = ifc.out_valid_o && !ifc.out_ready_i;
            prev_res   = ifc.result_o;
        end
    end

    initial begin
        vecs[0] = '{32'h101010FF, 32'h20202001, 32'h55555555, 1'b0, 2'b00, 32'h30303000, 4'b0001};
        vecs[1] = '{32'h101010F0, 32'h20202020, 32'h00000010, 1'b1, 2'b01, 32'h303030FF, 4'b0001};
        vecs[2] = '{32'h101010F0, 32'h20202020, 32'h10101010, 1'b0, 2'b01, 32'h303030FF, 4'b0001};
        vecs[3] = '{32'h0005807F, 32'h00FEFF01, 32'h00010000, 1'b1, 2'b10, 32'h0004807F, 4'b0011};
        vecs[4] = '{32'h80FF7F01, 32'h80010101, 32'h01010101, 1'b1, 2'b11, 32'h01018103, 4'b1100};
        vecs[5] = '{32'hC0404080, 32'hC03F4080, 32'h0000007F, 1'b1, 2'b10, 32'h807F7F80, 4'b0011};
        vecs[6] = '{32'h8000FEFF, 32'h7F0001FF, 32'h010000FF, 1'b1, 2'b01, 32'hFF00FFFF, 4'b1001};
        vecs[7] = '{32'h000001FF, 32'h00000101, 32'h00000000, 1'b0, 2'b01, 32'h000002FF, 4'b0001};

        rst             = 1'b1;
        ifc.in_valid_i  = 1'b0;
        ifc.op_0_i      = '0;
        ifc.op_1_i      = '0;
        ifc.op_2_i      = '0;
        ifc.op2_en_i    = 1'b0;
        ifc.mode_i      = 2'b00;
        ifc.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", 64'(ifc.out_valid_o), 64'd0);
        chk("reset_result", 64'(ifc.result_o), 64'd0);
        chk("reset_in_ready", 64'(ifc.in_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors: exact latency and value.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].en, vecs[i].mode);
            for (int k = 1; k <= PIPE; k++) begin
                @(negedge clk);
                if (k < PIPE) chk($sformatf("vec%0d_early_valid", i), 64'(ifc.out_valid_o), 64'd0);
            end
            chk($sformatf("vec%0d_valid", i), 64'(ifc.out_valid_o), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(ifc.result_o), 64'(vecs[i].res));
`ifdef VPU_IADD_OVF_FLAG_EN
            chk($sformatf("vec%0d_ovf", i), 64'(ifc.ovf_o), 64'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
        end

        // Backpressure: A, B, C back-to-back with the output blocked.
        ifc.out_ready_i = 1'b0;
        fork
            begin
                send(32'h01020304, 32'h10101010, 32'h0, 1'b0, 2'b00);
                send(32'h01020304, 32'h20202020, 32'h0, 1'b0, 2'b00);
                send(32'h01020304, 32'h30303030, 32'h0, 1'b0, 2'b00);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (ifc.out_valid_o) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_first_valid", 64'(seen), 64'd1);
                for (int n = 0; n < 5; n++) begin
                    if (n > 0) @(negedge clk);
                    chk("bp_in_ready_low", 64'(ifc.in_ready_o), 64'd0);
                    chk("bp_result_holds_a", 64'(ifc.result_o), 64'h11121314);
                end
                @(posedge clk);
                #1 ifc.out_ready_i = 1'b1;
                @(negedge clk);
                chk("bp_order_a", 64'(ifc.result_o), 64'h11121314);
                @(negedge clk);
                chk("bp_order_b_valid", 64'(ifc.out_valid_o), 64'd1);
                chk("bp_order_b", 64'(ifc.result_o), 64'h21222324);
                @(negedge clk);
                chk("bp_order_c_valid", 64'(ifc.out_valid_o), 64'd1);
                chk("bp_order_c", 64'(ifc.result_o), 64'h31323334);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight.
        ifc.out_ready_i = 1'b0;
        send(32'hAAAAAAAA, 32'h01010101, 32'h0, 1'b0, 2'b00);
        send(32'h55555555, 32'h01010101, 32'h0, 1'b0, 2'b00);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(ifc.out_valid_o), 64'd0);
        chk("rst_mid_result", 64'(ifc.result_o), 64'd0);
        chk("rst_mid_in_ready", 64'(ifc.in_ready_o), 64'd1);
        ifc.out_ready_i = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(ifc.out_valid_o), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random output backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    send(RW'($urandom), RW'($urandom), RW'($urandom), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 ifc.out_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ifc.out_ready_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("drain_out_valid", 64'(ifc.out_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
